button_conditioner: RTL and testbench

Parametrised multi-channel push-button conditioner: per channel it synchronises a raw asynchronous button input, debounces it, and emits a stable level plus single-cycle press, release and auto-repeat pulses. It sits between the board buttons and game/control logic, replacing per-button debounce instances with one block covering all directional and centre buttons.

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, debounce counter,
// registered press/release pulses and a per-channel auto-repeat state machine.
module button_conditioner #(
    parameter int unsigned         CHANNELS             = 5,
    parameter int unsigned         STABLE_CYCLES        = 1000000,
    parameter int unsigned         REPEAT_DELAY_CYCLES  = 50000000,
    parameter int unsigned         REPEAT_PERIOD_CYCLES = 10000000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK          = {CHANNELS{1'b1}}
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_button,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat
);

    localparam int unsigned CW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RPT   = 2'd2
    } rpt_state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]    sync_q;
        logic [CW-1:0] cnt_q;
        logic [RW-1:0] rcnt_q;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        rpt_state_e    state_q;
        logic          differ_c;
        logic          settle_c;

        // settle_c marks the edge on which the debounced level flips
        assign differ_c = (sync_q[1] != level_q);
        assign settle_c = differ_c && (cnt_q == CNT_LAST);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync_q    <= 2'b00;
                cnt_q     <= '0;
                rcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state_q   <= ST_IDLE;
            end else begin
                sync_q    <= {sync_q[0], i_button[ch]};
                press_q   <= settle_c && !level_q;
                release_q <= settle_c && level_q;
                repeat_q  <= 1'b0;

                if (!differ_c) begin
                    cnt_q <= '0;
                end else if (settle_c) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end

                // a debounced fall wins over any pending repeat pulse
                if (settle_c && level_q) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (settle_c && REPEAT_MASK[ch]) begin
                                state_q <= ST_DELAY;
                                rcnt_q  <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (rcnt_q == DLY_LAST) begin
                                repeat_q <= 1'b1;
                                state_q  <= ST_RPT;
                                rcnt_q   <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RW'(1);
                            end
                        end
                        ST_RPT: begin
                            if (rcnt_q == PER_LAST) begin
                                repeat_q <= 1'b1;
                                rcnt_q   <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RW'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end

        assign o_level[ch]   = level_q;
        assign o_press[ch]   = press_q;
        assign o_release[ch] = release_q;
        assign o_repeat[ch]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: per-cycle comparison against a run-length /
// hold-age model, plus directed literal checks for each scenario.
module tb_button_conditioner;

    localparam int unsigned CH     = 5;
    localparam int unsigned STABLE = 4;
    localparam int unsigned DLY    = 10;
    localparam int unsigned PER    = 3;
    localparam logic [CH-1:0] MASK = 5'b11101;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [CH-1:0] i_button;
    logic [CH-1:0] o_level, o_press, o_release, o_repeat;

    int tests = 0;
    int fails = 0;

    button_conditioner #(
        .CHANNELS            (CH),
        .STABLE_CYCLES       (STABLE),
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_PERIOD_CYCLES(PER),
        .REPEAT_MASK         (MASK)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_button (i_button),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_repeat (o_repeat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: synchroniser as a 2-deep delay line, debounce as a run length of
    // disagreement, repeat from the number of edges since the press.
    bit          m_s1 [CH];
    bit          m_s2 [CH];
    bit          m_lvl[CH];
    int unsigned m_run[CH];
    int unsigned m_age[CH];
    logic [CH-1:0] e_press, e_rel, e_rep, e_level;
    bit old_s2;

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            if (i_rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
                m_run[c] = 0; m_age[c] = 0;
                e_press[c] = 0; e_rel[c] = 0; e_rep[c] = 0;
            end else begin
                old_s2 = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = i_button[c];
                e_press[c] = 0; e_rel[c] = 0; e_rep[c] = 0;
                if (old_s2 != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == STABLE) begin
                        m_lvl[c] = old_s2;
                        m_run[c] = 0;
                        if (old_s2) e_press[c] = 1; else e_rel[c] = 1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (e_press[c]) m_age[c] = 0;
                else if (m_lvl[c]) m_age[c]++;
                if (MASK[c] && m_lvl[c] && !e_press[c] && m_age[c] >= DLY &&
                    ((m_age[c] - DLY) % PER) == 0)
                    e_rep[c] = 1;
            end
            e_level[c] = m_lvl[c];
        end
        chk("cyc_level",   32'(o_level),   32'(e_level));
        chk("cyc_press",   32'(o_press),   32'(e_press));
        chk("cyc_release", 32'(o_release), 32'(e_rel));
        chk("cyc_repeat",  32'(o_repeat),  32'(e_rep));
    end

    logic [CH-1:0] acc_press, acc_rel, acc_rep;
    logic [31:0]   obs;

    task automatic clr_acc();
        acc_press = '0; acc_rel = '0; acc_rep = '0;
    endtask

    task automatic wait_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            acc_press |= o_press;
            acc_rel   |= o_release;
            acc_rep   |= o_repeat;
        end
    endtask

    initial begin
        i_rst    = 1'b1;
        i_button = 5'b11111;
        clr_acc();

        // 1: reset with all buttons held, then debounce from scratch
        wait_n(5);
        chk("t1_rst_outs", 32'({o_level, o_press, o_release, o_repeat}), 32'd0);
        i_rst = 1'b0;
        wait_n(5);
        chk("t1_level_early", 32'(o_level), 32'd0);
        wait_n(1);
        chk("t1_level", 32'(o_level), 32'h1f);
        chk("t1_press", 32'(o_press), 32'h1f);
        wait_n(1);
        chk("t1_press_gone", 32'(o_press), 32'd0);
        i_button = '0;
        wait_n(10);
        chk("t1_released", 32'(o_level), 32'd0);

        // 2: clean press and release on ch0
        i_button = 5'b00001;
        wait_n(6);
        chk("t2_press", 32'(o_press[0]), 32'd1);
        chk("t2_level", 32'(o_level[0]), 32'd1);
        wait_n(1);
        chk("t2_press_1cyc", 32'(o_press[0]), 32'd0);
        i_button = '0;
        wait_n(6);
        chk("t2_release", 32'(o_release[0]), 32'd1);
        chk("t2_level0", 32'(o_level[0]), 32'd0);
        wait_n(4);

        // 3: bounce rejection, then a just-long-enough press
        clr_acc();
        i_button = 5'b00001; wait_n(3);
        i_button = 5'b00000; wait_n(1);
        i_button = 5'b00001; wait_n(3);
        i_button = 5'b00000; wait_n(8);
        chk("t3_no_press", 32'(acc_press), 32'd0);
        chk("t3_no_rel", 32'(acc_rel), 32'd0);
        chk("t3_level", 32'(o_level[0]), 32'd0);
        i_button = 5'b00001; wait_n(4);
        i_button = 5'b00000; wait_n(2);
        chk("t3_press4", 32'(o_press[0]), 32'd1);
        wait_n(12);

        // 4: auto-repeat on ch0
        i_button = 5'b00001;
        wait_n(6);
        chk("t4_press", 32'(o_press[0]), 32'd1);
        obs = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_repeat[0]) obs[k] = 1'b1;
        end
        chk("t4_repeat_offsets", obs, 32'h1249_2400);
        i_button = '0;
        wait_n(6);
        chk("t4_release", 32'(o_release[0]), 32'd1);
        chk("t4_no_rep_at_rel", 32'(o_repeat[0]), 32'd0);
        clr_acc();
        wait_n(10);
        chk("t4_no_rep_after", 32'(acc_rep), 32'd0);

        // 5: masked channel ch1 never repeats
        i_button = 5'b00010;
        wait_n(6);
        chk("t5_press", 32'(o_press), 32'h02);
        clr_acc();
        wait_n(25);
        chk("t5_no_repeat", 32'(acc_rep), 32'd0);
        i_button = '0;
        wait_n(10);

        // 6: simultaneous ch1/ch3, then reset while ch3 is repeating
        i_button = 5'b01010;
        wait_n(6);
        chk("t6_press", 32'(o_press), 32'h0a);
        wait_n(14);
        chk("t6_level", 32'(o_level), 32'h0a);
        i_rst = 1'b1;
        i_button = '0;
        wait_n(1);
        chk("t6_rst_outs", 32'({o_level, o_press, o_release, o_repeat}), 32'd0);
        wait_n(1);
        i_rst = 1'b0;
        clr_acc();
        wait_n(10);
        chk("t6_no_release", 32'(acc_rel), 32'd0);
        chk("t6_no_press", 32'(acc_press), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
